ysyx_25020037_fwd_buf: RTL and testbench

Parametrised forwarding buffer for the EX stage: records the last DEPTH register writes in age order and serves NREAD combinational source-operand lookups, newest match first. Load results are installed later by an in-order load-completion port; lookups that hit a still-pending load raise a per-port wait. The buffer sits between the decode/regfile read path and the ALU operand muxes, and replaces fixed two-port, four-entry bypass logic with depth, port count, width and load-forward mode as parameters.

---
 rtl/ysyx_25020037_fwd_buf_if.sv | 27 ++
 rtl/ysyx_25020037_fwd_buf.sv | 91 +++++++++
 tb/tb_ysyx_25020037_fwd_buf.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_fwd_buf_if.sv
// ysyx_25020037_fwd_buf_if: push, load-completion and lookup bundle between the EX stage and its forwarding buffer
interface ysyx_25020037_fwd_buf_if #(parameter int NREAD = 2, parameter int XLEN = 32);
  logic push_valid;
  logic push_we;
  logic [4:0] push_rd;
  logic [XLEN-1:0] push_data;
  logic push_is_load;
  logic push_ready;
  logic ld_done_valid;
  logic [XLEN-1:0] ld_done_data;
  logic clr;
  logic [NREAD*5-1:0] rd_addr;
  logic [NREAD*XLEN-1:0] rd_rf_data;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0] rd_hit;
  logic [NREAD-1:0] rd_wait;
  modport master (
    output push_valid, push_we, push_rd, push_data, push_is_load,
    output ld_done_valid, ld_done_data, clr, rd_addr, rd_rf_data,
    input push_ready, rd_data, rd_hit, rd_wait
  );
  modport slave (
    input push_valid, push_we, push_rd, push_data, push_is_load,
    input ld_done_valid, ld_done_data, clr, rd_addr, rd_rf_data,
    output push_ready, rd_data, rd_hit, rd_wait
  );
endinterface

// File: rtl/ysyx_25020037_fwd_buf.sv
// ysyx_25020037_fwd_buf: age-ordered EX-stage forwarding buffer with in-order load completion
module ysyx_25020037_fwd_buf #(
  parameter int DEPTH = 4,
  parameter int NREAD = 2,
  parameter int XLEN = 32,
  parameter int LD_FWD = 0
) (
  input logic clk,
  input logic rst,
  ysyx_25020037_fwd_buf_if.slave bus,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt,
  output logic ld_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] valid, pend, valid_n, pend_n;
  logic [4:0] rd [DEPTH];
  logic [4:0] rd_n [DEPTH];
  logic [XLEN-1:0] data [DEPTH];
  logic [XLEN-1:0] data_n [DEPTH];
  logic [IW-1:0] old_idx;
  logic has_pend, do_push, new_valid;
  always_comb begin
    old_idx = '0;
    has_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && pend[i]) begin
        old_idx = IW'(i);
        has_pend = 1'b1;
      end
  end
  assign bus.push_ready = !(valid[DEPTH-1] && pend[DEPTH-1]) || bus.ld_done_valid;
  assign do_push = bus.push_valid && bus.push_ready;
  assign new_valid = bus.push_we && bus.push_rd != 5'd0;
  // completion lands before the shift so it follows the entry to its new slot
  always_comb begin
    valid_n = valid;
    pend_n = pend;
    rd_n = rd;
    data_n = data;
    if (bus.clr) begin
      valid_n = '0;
      pend_n = '0;
    end else if (bus.ld_done_valid && has_pend) begin
      data_n[old_idx] = bus.ld_done_data;
      pend_n[old_idx] = 1'b0;
    end
    if (do_push) begin
      valid_n = {valid_n[DEPTH-2:0], new_valid};
      pend_n = {pend_n[DEPTH-2:0], new_valid && bus.push_is_load};
      for (int i = DEPTH-1; i > 0; i--) begin
        rd_n[i] = rd_n[i-1];
        data_n[i] = data_n[i-1];
      end
      rd_n[0] = bus.push_rd;
      data_n[0] = bus.push_is_load ? '0 : bus.push_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      pend <= '0;
      ld_err <= 1'b0;
    end else begin
      valid <= valid_n;
      pend <= pend_n;
      rd <= rd_n;
      data <= data_n;
      if (bus.ld_done_valid && !has_pend && !bus.clr) ld_err <= 1'b1;
    end
  end
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) pend_cnt = pend_cnt + CW'(valid[i] && pend[i]);
  end
  // scanning oldest to newest lets the newest match overwrite older ones
  always_comb begin
    bus.rd_data = '0;
    bus.rd_hit = '0;
    bus.rd_wait = '0;
    for (int k = 0; k < NREAD; k++) begin
      bus.rd_data[XLEN*k +: XLEN] = bus.rd_rf_data[XLEN*k +: XLEN];
      for (int i = DEPTH-1; i >= 0; i--)
        if (valid[i] && rd[i] == bus.rd_addr[5*k +: 5] && bus.rd_addr[5*k +: 5] != 5'd0) begin
          bus.rd_hit[k] = 1'b1;
          bus.rd_data[XLEN*k +: XLEN] = (LD_FWD != 0 && bus.ld_done_valid && pend[i] && IW'(i) == old_idx) ? bus.ld_done_data : data[i];
          bus.rd_wait[k] = pend[i] && !(LD_FWD != 0 && bus.ld_done_valid && IW'(i) == old_idx);
        end
    end
  end
endmodule

// File: tb/tb_ysyx_25020037_fwd_buf.sv
// tb_ysyx_25020037_fwd_buf: vector table, corner sequences and random traffic against a queue-based model
module tb_ysyx_25020037_fwd_buf;
  localparam int D = 4;
  localparam int N = 2;
  localparam logic [31:0] RF0 = 32'hF0F0_0000;
  localparam logic [31:0] RF1 = 32'h0F0F_0000;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  ysyx_25020037_fwd_buf_if #(.NREAD(N), .XLEN(32)) ia ();
  ysyx_25020037_fwd_buf_if #(.NREAD(N), .XLEN(32)) ib ();
  logic [2:0] cnt_a, cnt_b;
  logic err_a, err_b;
  ysyx_25020037_fwd_buf #(.DEPTH(D), .NREAD(N), .XLEN(32), .LD_FWD(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ia), .pend_cnt(cnt_a), .ld_err(err_a));
  ysyx_25020037_fwd_buf #(.DEPTH(D), .NREAD(N), .XLEN(32), .LD_FWD(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib), .pend_cnt(cnt_b), .ld_err(err_b));
  assign ib.push_valid = ia.push_valid;
  assign ib.push_we = ia.push_we;
  assign ib.push_rd = ia.push_rd;
  assign ib.push_data = ia.push_data;
  assign ib.push_is_load = ia.push_is_load;
  assign ib.ld_done_valid = ia.ld_done_valid;
  assign ib.ld_done_data = ia.ld_done_data;
  assign ib.clr = ia.clr;
  assign ib.rd_addr = ia.rd_addr;
  assign ib.rd_rf_data = ia.rd_rf_data;

  typedef struct {bit v; bit p; logic [4:0] rd; logic [31:0] d;} ent_t;
  typedef struct {
    bit pv; bit we; logic [4:0] rd; logic [31:0] dat; bit ld; bit ldv; logic [31:0] ldd; logic [4:0] a0;
    bit hit; bit wt; logic [31:0] data; bit rdy; int cnt;
  } vec_t;
  ent_t q[$];
  bit m_err;
  bit chk_en;
  int checks = 0;
  int errors = 0;
  vec_t tbl[19];

  function automatic int oldest();
    int o = -1;
    foreach (q[i]) if (q[i].v && q[i].p) o = i;
    return o;
  endfunction
  function automatic int m_cnt();
    int c = 0;
    foreach (q[i]) if (q[i].v && q[i].p) c++;
    return c;
  endfunction
  function automatic bit m_ready();
    return !(q[D-1].v && q[D-1].p) || ia.ld_done_valid;
  endfunction

  task automatic m_reset();
    q.delete();
    repeat (D) q.push_back('{v: 1'b0, p: 1'b0, rd: 5'd0, d: 32'd0});
    m_err = 1'b0;
  endtask

  task automatic lookup(input int k, input bit fwd, output bit h, output bit w, output logic [31:0] d);
    logic [4:0] a;
    a = ia.rd_addr[5*k +: 5];
    h = 1'b0;
    w = 1'b0;
    d = ia.rd_rf_data[32*k +: 32];
    if (a != 5'd0)
      for (int i = 0; i < D; i++)
        if (q[i].v && q[i].rd == a) begin
          h = 1'b1;
          w = q[i].p;
          d = q[i].d;
          if (fwd && w && i == oldest() && ia.ld_done_valid) begin
            w = 1'b0;
            d = ia.ld_done_data;
          end
          break;
        end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit h, w;
    logic [31:0] d;
    chk("ready_a", ia.push_ready, m_ready());
    chk("ready_b", ib.push_ready, m_ready());
    chk("cnt_a", cnt_a, m_cnt());
    chk("cnt_b", cnt_b, m_cnt());
    chk("err_a", err_a, m_err);
    chk("err_b", err_b, m_err);
    for (int k = 0; k < N; k++) begin
      lookup(k, 1'b0, h, w, d);
      chk("hit_a", ia.rd_hit[k], h);
      chk("wait_a", ia.rd_wait[k], w);
      chk("data_a", ia.rd_data[32*k +: 32], d);
      lookup(k, 1'b1, h, w, d);
      chk("hit_b", ib.rd_hit[k], h);
      chk("wait_b", ib.rd_wait[k], w);
      chk("data_b", ib.rd_data[32*k +: 32], d);
    end
  endtask

  task automatic m_step();
    int o;
    bit r;
    ent_t e;
    if (rst) begin
      m_reset();
      return;
    end
    o = oldest();
    r = m_ready();
    if (ia.clr) foreach (q[i]) begin
      q[i].v = 1'b0;
      q[i].p = 1'b0;
    end else if (ia.ld_done_valid) begin
      if (o >= 0) begin
        q[o].d = ia.ld_done_data;
        q[o].p = 1'b0;
      end else m_err = 1'b1;
    end
    if (ia.push_valid && r) begin
      e.v = ia.push_we && ia.push_rd != 5'd0;
      e.p = e.v && ia.push_is_load;
      e.rd = ia.push_rd;
      e.d = ia.push_is_load ? 32'd0 : ia.push_data;
      q.push_front(e);
      void'(q.pop_back());
    end
  endtask

  task automatic cyc();
    #1;
    if (chk_en) check_model();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit pv, input bit we, input logic [4:0] rd, input logic [31:0] dat, input bit ld,
                       input bit ldv, input logic [31:0] ldd, input bit cl, input logic [4:0] a0, input logic [4:0] a1);
    ia.push_valid = pv;
    ia.push_we = we;
    ia.push_rd = rd;
    ia.push_data = dat;
    ia.push_is_load = ld;
    ia.ld_done_valid = ldv;
    ia.ld_done_data = ldd;
    ia.clr = cl;
    ia.rd_addr = {a1, a0};
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, RF0, 1, 0};
    tbl[1]  = '{1, 1, 5, 32'h11, 0, 0, 0, 5, 0, 0, RF0, 1, 0};
    tbl[2]  = '{1, 1, 5, 32'h22, 0, 0, 0, 5, 1, 0, 32'h11, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 32'h22, 1, 0};
    tbl[4]  = '{1, 1, 7, 32'h999, 1, 0, 0, 7, 0, 0, RF0, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 32'hDEAD, 7, 1, 1, 0, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 32'hDEAD, 1, 0};
    tbl[8]  = '{1, 1, 3, 32'h5, 1, 0, 0, 3, 0, 0, RF0, 1, 0};
    tbl[9]  = '{1, 1, 4, 32'h44, 0, 0, 0, 3, 1, 1, 0, 1, 1};
    tbl[10] = '{1, 1, 5, 32'h55, 0, 0, 0, 4, 1, 0, 32'h44, 1, 1};
    tbl[11] = '{1, 1, 6, 32'h66, 0, 0, 0, 5, 1, 0, 32'h55, 1, 1};
    tbl[12] = '{1, 1, 9, 32'h99, 0, 0, 0, 3, 1, 1, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 0, RF0, 0, 1};
    tbl[14] = '{1, 1, 9, 32'h99, 0, 1, 32'h33, 4, 1, 0, 32'h44, 1, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 32'h44, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 0, RF0, 1, 0};
    tbl[17] = '{1, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0, RF0, 1, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RF0, 1, 0};
    rst = 1'b1;
    chk_en = 1'b0;
    ia.rd_rf_data = {RF1, RF0};
    idle(0, 0);
    m_reset();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].we, tbl[i].rd, tbl[i].dat, tbl[i].ld, tbl[i].ldv, tbl[i].ldd, 1'b0, tbl[i].a0, 5'd0);
      #1;
      chk($sformatf("tbl%0d_hit", i), ia.rd_hit[0], tbl[i].hit);
      chk($sformatf("tbl%0d_wait", i), ia.rd_wait[0], tbl[i].wt);
      chk($sformatf("tbl%0d_data", i), ia.rd_data[31:0], tbl[i].data);
      chk($sformatf("tbl%0d_ready", i), ia.push_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].cnt);
      cyc();
    end
    rst = 1'b1;
    idle(0, 0);
    cyc();
    rst = 1'b0;
    drive(1, 1, 8, 0, 1, 0, 0, 0, 8, 9);
    cyc();
    drive(1, 1, 9, 0, 1, 0, 0, 0, 8, 9);
    cyc();
    idle(8, 9);
    #1;
    chk("two_pend_cnt", cnt_a, 2);
    chk("x8_wait", ia.rd_wait[0], 1);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 32'h1, 0, 8, 9);
    #1;
    chk("fwd_x8_data", ib.rd_data[31:0], 32'h1);
    chk("fwd_x8_wait", ib.rd_wait[0], 0);
    chk("nofwd_x8_wait", ia.rd_wait[0], 1);
    cyc();
    drive(1, 1, 11, 32'hBB, 0, 1, 32'h2, 0, 8, 9);
    #1;
    chk("fwd_x9_data", ib.rd_data[63:32], 32'h2);
    cyc();
    idle(8, 9);
    #1;
    chk("x8_data", ia.rd_data[31:0], 32'h1);
    chk("x9_data", ia.rd_data[63:32], 32'h2);
    chk("loads_done_cnt", cnt_a, 0);
    cyc();
    drive(1, 1, 12, 0, 1, 0, 0, 0, 10, 12);
    cyc();
    drive(1, 1, 10, 0, 1, 1, 32'h5, 1, 10, 12);
    cyc();
    idle(10, 12);
    #1;
    chk("clr_x10_hit", ia.rd_hit[0], 1);
    chk("clr_x10_wait", ia.rd_wait[0], 1);
    chk("clr_x12_hit", ia.rd_hit[1], 0);
    chk("clr_cnt", cnt_a, 1);
    chk("clr_err", err_a, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 32'h6, 0, 10, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 32'h7, 0, 10, 0);
    #1;
    chk("empty_cnt", cnt_a, 0);
    cyc();
    idle(0, 0);
    repeat (3) cyc();
    #1;
    chk("err_sticky", err_a, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("err_rst", err_a, 0);
    drive(1, 1, 13, 0, 1, 0, 0, 0, 13, 0);
    cyc();
    rst = 1'b1;
    idle(13, 0);
    cyc();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 32'h8, 0, 13, 0);
    cyc();
    idle(13, 0);
    #1;
    chk("err_after_rst_drop", err_a, 1);
    chk("x13_gone", ia.rd_hit[0], 0);
    cyc();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 29) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      ia.rd_rf_data = {$urandom, $urandom};
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
